// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - 32-bit signed Booth multiply / restoring divide producing HI and LO
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_t;

   state_t      state_q, state_d;
   logic [32:0] acc_q, acc_d;
   logic [31:0] q_q, q_d;
   logic [31:0] m_q, m_d;
   logic        qm1_q, qm1_d;
   logic [4:0]  count_q, count_d;
   logic        sign_q_q, sign_q_d;
   logic        sign_r_q, sign_r_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;
   logic        div_zero_q, div_zero_d;
   logic        dz_pend_q, dz_pend_d;

   logic [32:0] m_ext;
   logic [32:0] booth_sum;
   logic [32:0] mult_acc;
   logic [31:0] mult_q;
   logic [32:0] r_sh;
   logic [32:0] trial;
   logic [32:0] div_r;
   logic [31:0] div_q;
   logic [31:0] abs_a;
   logic [31:0] abs_b;

   always_comb begin
      m_ext = {m_q[31], m_q};
      case ({q_q[0], qm1_q})
         2'b01:   booth_sum = acc_q + m_ext;
         2'b10:   booth_sum = acc_q - m_ext;
         default: booth_sum = acc_q;
      endcase
      mult_acc = {booth_sum[32], booth_sum[32:1]};
      mult_q   = {booth_sum[0], q_q[31:1]};

      // remainder never exceeds the divisor magnitude, so its low 32 bits suffice for the shift
      r_sh  = {acc_q[31:0], q_q[31]};
      trial = r_sh - {1'b0, m_q};
      div_r = trial[32] ? r_sh : trial;
      div_q = {q_q[30:0], ~trial[32]};

      abs_a = a[31] ? (~a + 32'd1) : a;
      abs_b = b[31] ? (~b + 32'd1) : b;
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      q_d        = q_q;
      m_d        = m_q;
      qm1_d      = qm1_q;
      count_d    = count_q;
      sign_q_d   = sign_q_q;
      sign_r_d   = sign_r_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      dz_pend_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (dz_pend_q) begin
               done_d     = 1'b1;
               div_zero_d = 1'b1;
            end else if (start) begin
               count_d = 5'd0;
               acc_d   = 33'd0;
               qm1_d   = 1'b0;
               if (!op) begin
                  state_d = S_MULT;
                  q_d     = b;
                  m_d     = a;
               end else if (b != 32'd0) begin
                  state_d  = S_DIV;
                  q_d      = abs_a;
                  m_d      = abs_b;
                  sign_q_d = a[31] ^ b[31];
                  sign_r_d = a[31];
               end else begin
                  dz_pend_d = 1'b1;
               end
            end
         end
         S_MULT: begin
            acc_d   = mult_acc;
            q_d     = mult_q;
            qm1_d   = q_q[0];
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) begin
               hi_d    = mult_acc[31:0];
               lo_d    = mult_q;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DIV: begin
            acc_d   = div_r;
            q_d     = div_q;
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) begin
               lo_d    = sign_q_q ? (~div_q + 32'd1) : div_q;
               hi_d    = sign_r_q ? (~div_r[31:0] + 32'd1) : div_r[31:0];
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         acc_q      <= 33'd0;
         q_q        <= 32'd0;
         m_q        <= 32'd0;
         qm1_q      <= 1'b0;
         count_q    <= 5'd0;
         sign_q_q   <= 1'b0;
         sign_r_q   <= 1'b0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         dz_pend_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         q_q        <= q_d;
         m_q        <= m_d;
         qm1_q      <= qm1_d;
         count_q    <= count_d;
         sign_q_q   <= sign_q_d;
         sign_r_q   <= sign_r_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         dz_pend_q  <= dz_pend_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   mult_div_unit dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   logic prev_done = 1'b0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (done) begin
         check("busy_with_done", {31'd0, busy}, 32'd0);
         check("done_one_cycle", {31'd0, prev_done}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_hi"}, hi, mon_e.hi);
            check({mon_e.name, "_lo"}, lo, mon_e.lo);
            check({mon_e.name, "_div_zero"}, {31'd0, div_zero}, {31'd0, mon_e.dz});
            check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.cyc));
         end
      end
      prev_done <= done;
   end

   task automatic issue(input string name, input logic o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz, input int lat);
      exp_t e;
      op    = o;
      a     = aa;
      b     = bb;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      e.name = name;
      e.hi   = eh;
      e.lo   = el;
      e.dz   = edz;
      e.cyc  = cyc + lat;
      sb.push_back(e);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_done_high();
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_wait_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_div_zero", {31'd0, div_zero}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      issue("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32);
      wait_empty();
      issue("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 32);
      wait_empty();
      issue("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 32);
      wait_done_high();
      issue("div_m7_2_b2b", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
      wait_empty();
      issue("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 32);
      wait_empty();
      issue("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
      wait_empty();
      issue("mul_shift", 1'b0, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780, 1'b0, 32);
      wait_empty();
      issue("div_prep", 1'b1, 32'h0ACF_1234, 32'h2000, 32'h1234, 32'h5678, 1'b0, 32);
      wait_empty();

      issue("div_by_zero", 1'b1, 32'd5, 32'd0, 32'h1234, 32'h5678, 1'b1, 1);
      @(negedge clk);
      check("dz_busy_e0", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("dz_busy_e1", {31'd0, busy}, 32'd0);
      wait_empty();
      check("dz_flag_cleared", {31'd0, div_zero}, 32'd0);

      issue("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32);
      repeat (9) @(posedge clk);
      #1;
      op    = 1'b0;
      a     = 32'd3;
      b     = 32'd4;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_empty();
      repeat (40) @(negedge clk);

      op    = 1'b0;
      a     = 32'h1111_1111;
      b     = 32'd5;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      issue("mul_3_4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 32);
      wait_empty();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle signed multiply/divide unit producing the HI and LO registers for the datapath. It is started by the control FSM and iterates one bit per cycle. HI and LO are held as outputs that feed the write-data source select of the register bank. It reports completion with a one-cycle `done` pulse and flags divide-by-zero.

## Interface
- No parameters; datapath width fixed at 32 bits.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request operation; sampled only in IDLE.
- `op` in 1: 0 = signed multiply (MULT), 1 = signed divide (DIV); sampled with `start`.
- `a` in 32: multiplicand / dividend; sampled with `start`.
- `b` in 32: multiplier / divisor; sampled with `start`.
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse; HI/LO valid (or `div_zero` valid) in this cycle.
- `div_zero` out 1: high with `done` when DIV had `b == 0`; low otherwise.
- `hi` out 32: MULT: product[63:32]; DIV: remainder.
- `lo` out 32: MULT: product[31:0]; DIV: quotient.

## Operation
- FSM states: IDLE, MULT, DIV.
- IDLE + `start` + `op`=0 → MULT.
  - Load a radix-2 Booth accumulator {A=0, Q=b, q-1=0}, M=a, count=0.
- IDLE + `start` + `op`=1 + `b`≠0 → DIV.
  - Store |a|, |b|, sign_q = a[31]^b[31], sign_r = a[31].
  - Run restoring division on magnitudes, 32 iterations.
- IDLE + `start` + `op`=1 + `b`=0 → stays IDLE.
  - Next edge: `done`=1, `div_zero`=1; `hi`/`lo` unchanged.
- MULT iteration (per edge):
  - Inspect {Q[0], q-1}: 01 → A+=M, 10 → A-=M, 00/11 → nothing.
  - Then arithmetic right shift of {A,Q,q-1}.
  - A is 33 bits internally so A-M with M=0x80000000 does not overflow.
- DIV iteration: shift {R,Qd} left, trial-subtract divisor, set the quotient bit when the result is non-negative.
- Finish, on the 32nd iteration edge:
  - Load `hi`/`lo`; apply signs for DIV.
  - Set `done`=1 (cleared next edge); return to IDLE.
  - MULT: {hi,lo} = 64-bit two's-complement product.
  - DIV: lo = sign_q ? −Q : Q; hi = sign_r ? −R : R (truncating toward zero; remainder has the dividend's sign).
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no flag.
- `start` while `busy` is ignored; operands are not resampled.
- `hi`/`lo` hold their value between operations; they change only at a successful finish.
- `div_zero` is cleared on every new accepted `start`. It is asserted only in the `done` cycle of a div-by-zero.

## Timing
- Reset (async, `reset`=0): state=IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, iteration count=0.
- Reset mid-operation aborts immediately: no `done`, outputs zeroed.
- Accept edge E0 (IDLE, `start`=1):
  - `busy` rises after E0.
  - Iterations run at E1..E32.
  - At E32: `hi`/`lo` updated, `done`=1, `busy`=0.
  - At E33: `done`=0.
  - Latency 32 cycles from accept to `done`.
- Div-by-zero: accept at E0, `done`=`div_zero`=1 after E1 (`busy` stays 0); both clear at E2.
- Back-to-back: `start` held high during the `done` cycle is accepted at the following edge (E33). Throughput is one operation per 33 cycles.
- `busy` and `done` are never high together.

## Test plan
- MULT a=7, b=0xFFFFFFFD (−3) → at E32: hi=0xFFFFFFFF, lo=0xFFFFFFEB, `done` exactly one cycle, `div_zero`=0.
- MULT a=b=0x80000000 → hi=0x40000000, lo=0x00000000. Also a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Also a=7, b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- DIV a=5, b=0 with prior hi=0x1234, lo=0x5678 → `done`=`div_zero`=1 one cycle after accept; hi/lo unchanged; `busy` never high.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, `div_zero`=0. Pulse `start` with new operands at cycle 10 → ignored; result unaffected.
- Start MULT, drop `reset` at iteration 10 → busy/done/hi/lo=0 immediately. Release reset, start MULT 3×4 → lo=12, hi=0 after 32 cycles.
